// File: rtl/add_seq_ctrl.sv
// Multi-byte adder/subtractor sequencer: streams an NBYTES-wide operation through
// an external 8-bit ripple adder, one byte per clock, LSB first.
module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_cin,
  input  logic                  op_sub,
  output logic [7:0]            adder_a,
  output logic [7:0]            adder_b,
  output logic                  adder_cin,
  input  logic [7:0]            adder_sum,
  input  logic                  adder_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  out_cout,
  output logic                  out_ovf
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                   state_q, state_d;
  logic [NBYTES-1:0][7:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     cy_q, cy_d;
  logic                     cout_q, cout_d;
  logic                     ovf_q, ovf_d;
  logic                     last;

  assign last = (idx_q == IW'(NBYTES - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    idx_d     = idx_q;
    cy_d      = cy_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          // Subtraction is A + ~B + 1; carry-in is forced so op_cin is ignored.
          b_d     = op_sub ? ~op_b : op_b;
          cy_d    = op_sub | op_cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        adder_a      = a_q[idx_q];
        adder_b      = b_q[idx_q];
        adder_cin    = cy_q;
        res_d[idx_q] = adder_sum;
        cy_d         = adder_cout;
        idx_d        = idx_q + 1'b1;
        if (last) begin
          cout_d  = adder_cout;
          ovf_d   = (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &&
                    (adder_sum[7] != a_q[NBYTES-1][7]);
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        // No accept on the hand-off edge: IDLE must be visited first.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (NBYTES=4) with a behavioural 8-bit adder attached.
module tb_add_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        op_cin = 1'b0, op_sub = 1'b0;
  logic [7:0]  adder_a, adder_b, adder_sum;
  logic        adder_cin, adder_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        out_cout, out_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int xfers    = 0;

  always #5 clk = ~clk;

  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'b0, adder_cin};

  always @(posedge clk) if (out_valid && out_ready) xfers++;

  add_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // Presents one op for one edge, then scrambles the op inputs while it is in flight.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub);
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = 32'hDEADBEEF; op_b = 32'h5A5A5A5A; op_cin = ~cin; op_sub = ~sub;
  endtask

  // Edge count with the accept edge as edge 1; bounded at 20.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_out;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL rst_result: got %h exp 0", result); end
    n_checks++; if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL rst_flags: got %b exp 00", {out_cout, out_ovf}); end
    n_checks++; if ({adder_a, adder_b, adder_cin} !== 17'h0) begin n_fail++; $display("FAIL rst_adder: got %h exp 0", {adder_a, adder_b, adder_cin}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_carry_chain;
    int e;
    start_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL calc_ready: got %b exp 0", in_ready); end
    n_checks++; if ({adder_a, adder_b, adder_cin} !== {8'hFF, 8'h01, 1'b0}) begin n_fail++; $display("FAIL chain_byte0: got %h exp %h", {adder_a, adder_b, adder_cin}, {8'hFF, 8'h01, 1'b0}); end
    wait_done(e);
    n_checks++; if (e !== 5) begin n_fail++; $display("FAIL chain_latency: got %0d exp 5", e); end
    n_checks++; if (result !== 32'h00000100) begin n_fail++; $display("FAIL chain_result: got %h exp 00000100", result); end
    n_checks++; if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL chain_flags: got %b exp 00", {out_cout, out_ovf}); end
    n_checks++; if ({adder_a, adder_b, adder_cin} !== 17'h0) begin n_fail++; $display("FAIL done_adder: got %h exp 0", {adder_a, adder_b, adder_cin}); end
    release_out();
  endtask

  task automatic test_wrap;
    int e;
    start_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done(e);
    n_checks++; if (result !== 32'h00000000) begin n_fail++; $display("FAIL wrap_result: got %h exp 00000000", result); end
    n_checks++; if ({out_cout, out_ovf} !== 2'b10) begin n_fail++; $display("FAIL wrap_flags: got %b exp 10", {out_cout, out_ovf}); end
    release_out();
  endtask

  task automatic test_overflow;
    int e;
    start_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    wait_done(e);
    n_checks++; if (result !== 32'h80000000) begin n_fail++; $display("FAIL ovf_result: got %h exp 80000000", result); end
    n_checks++; if ({out_cout, out_ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags: got %b exp 01", {out_cout, out_ovf}); end
    release_out();
  endtask

  task automatic test_sub;
    int e;
    start_op(32'h00000005, 32'h00000007, 1'b0, 1'b1);
    n_checks++; if ({adder_a, adder_b, adder_cin} !== {8'h05, 8'hF8, 1'b1}) begin n_fail++; $display("FAIL sub_byte0: got %h exp %h", {adder_a, adder_b, adder_cin}, {8'h05, 8'hF8, 1'b1}); end
    wait_done(e);
    n_checks++; if (result !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL sub_result: got %h exp FFFFFFFE", result); end
    n_checks++; if ({out_cout, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL sub_flags: got %b exp 00", {out_cout, out_ovf}); end
    release_out();
    // cin must be ignored for subtraction: 0x10 - 0x10 = 0, no borrow
    start_op(32'h00000010, 32'h00000010, 1'b1, 1'b1);
    wait_done(e);
    n_checks++; if ({out_cout, out_ovf, result} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL sub_cin_ign: got %h exp %h", {out_cout, out_ovf, result}, {2'b10, 32'h0}); end
    release_out();
  endtask

  task automatic test_backpressure;
    int e;
    start_op(32'h01020304, 32'h10203040, 1'b0, 1'b0);
    wait_done(e);
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      op_a = $urandom; in_valid = 1'b1;
      n_checks++; if ({out_valid, in_ready, result} !== {2'b10, 32'h11223344}) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h exp %h", i, {out_valid, in_ready, result}, {2'b10, 32'h11223344}); end
    end
    release_out();
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_no_accept: got %b exp 01", {out_valid, in_ready}); end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (xfers !== 1) begin n_fail++; $display("FAIL bp_xfers: got %0d exp 1", xfers); end
  endtask

  task automatic test_back_to_back;
    int e;
    start_op(32'h12345678, 32'h11111111, 1'b1, 1'b0);
    wait_done(e);
    n_checks++; if ({out_cout, out_ovf, result} !== {2'b00, 32'h2345678A}) begin n_fail++; $display("FAIL b2b_first: got %h exp %h", {out_cout, out_ovf, result}, {2'b00, 32'h2345678A}); end
    release_out();
    start_op(32'h80000000, 32'h80000001, 1'b0, 1'b0);
    wait_done(e);
    n_checks++; if (e !== 5) begin n_fail++; $display("FAIL b2b_latency: got %0d exp 5", e); end
    n_checks++; if ({out_cout, out_ovf, result} !== {2'b11, 32'h00000001}) begin n_fail++; $display("FAIL b2b_second: got %h exp %h", {out_cout, out_ovf, result}, {2'b11, 32'h00000001}); end
    release_out();
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    int e;
    start_op(32'h11111111, 32'h22222222, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    n_checks++; if (adder_a !== 8'h11) begin n_fail++; $display("FAIL mid_pre: got %h exp 11", adder_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({out_valid, out_cout, out_ovf, result} !== 35'h0) begin n_fail++; $display("FAIL mid_outs: got %h exp 0", {out_valid, out_cout, out_ovf, result}); end
    n_checks++; if ({adder_a, adder_b, adder_cin} !== 17'h0) begin n_fail++; $display("FAIL mid_adder: got %h exp 0", {adder_a, adder_b, adder_cin}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b exp 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL mid_spurious: got %0d exp 0", seen); end
    start_op(32'h00000003, 32'h00000004, 1'b0, 1'b0);
    wait_done(e);
    n_checks++; if (result !== 32'h00000007) begin n_fail++; $display("FAIL mid_recover: got %h exp 00000007", result); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_wrap();
    test_overflow();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
